// File: rtl/vga_pkg.sv
// Shared video types: frame word, colour widths and
// the tail-FIFO synchronisation states.
package vga_pkg;

  localparam int R_SIZE   = 4;
  localparam int G_SIZE   = 4;
  localparam int B_SIZE   = 4;
  localparam int RGB_SIZE = R_SIZE + G_SIZE + B_SIZE;
  localparam int HC_W     = 10;
  localparam int VC_W     = 10;

  typedef struct packed {
    logic              start;
    logic [HC_W-1:0]   hc;
    logic [VC_W-1:0]   vc;
    logic [R_SIZE-1:0] r;
    logic [G_SIZE-1:0] g;
    logic [B_SIZE-1:0] b;
  } vga_frame_t;

  typedef enum logic [1:0] {
    WAIT_START,
    WAIT_ALIGN,
    RUN
  } vga_fifo_state_e;

endpackage

// File: rtl/vga_fifo_sync.sv
// Generic first-word-fall-through synchronous FIFO.
// Flush empties it in one edge and beats any push/pop.
module vga_fifo_sync #(
  parameter int AW = 4,
  parameter int DW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] r_mem [0:2**AW-1];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push & ~full & ~flush;
  assign w_pop  = pop & ~empty & ~flush;
  assign full   = r_count[AW];
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count
               + {{AW{1'b0}}, w_push}
               - {{AW{1'b0}}, w_pop};
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/video_frame_fifo.sv
// Tail elastic buffer: throttles upstream with stall and
// hands one pixel per request to VGA timing, frame-aligned.
module video_frame_fifo
  import vga_pkg::*;
#(
  parameter int FIFO_AW      = 4,
  parameter int STALL_MARGIN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                source_vld,
  input  vga_frame_t          source_frame,
  output logic                stall,
  input  logic                pixel_req,
  input  logic                vga_sof,
  output logic [RGB_SIZE-1:0] pixel_rgb,
  input  logic                clr_status,
  output logic                underrun,
  output logic                overflow,
  output logic                misalign
);

  localparam int DW = RGB_SIZE + 1;
  localparam int TH = 2**FIFO_AW - STALL_MARGIN;
  localparam logic [FIFO_AW:0] STALL_TH = TH[FIFO_AW:0];

  vga_fifo_state_e     r_state;
  logic [DW-1:0]       w_din;
  logic [DW-1:0]       w_dout;
  logic [FIFO_AW:0]    w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_flush;
  logic                w_set_un;
  logic                w_set_mis;
  logic                w_set_ov;
  logic                w_head_st;
  logic [RGB_SIZE-1:0] w_head_rgb;
  logic                w_unused_hv;

  assign w_unused_hv = ^{source_frame.hc, source_frame.vc};

  assign w_din = {source_frame.start, source_frame.r,
                  source_frame.g, source_frame.b};
  assign w_head_st  = w_dout[RGB_SIZE];
  assign w_head_rgb = w_dout[RGB_SIZE-1:0];

  assign stall    = (w_count >= STALL_TH);
  assign w_set_ov = source_vld & w_full;
  assign w_push   = source_vld & ~w_full & ~w_flush &
                    ((r_state != WAIT_START) |
                     source_frame.start);

  // Read-side decode: pop, error detection and flush.
  always_comb begin
    w_pop     = 1'b0;
    w_flush   = 1'b0;
    w_set_un  = 1'b0;
    w_set_mis = 1'b0;
    if (pixel_req) begin
      unique case (r_state)
        WAIT_ALIGN: w_pop = vga_sof;
        RUN: begin
          if (w_empty) begin
            w_set_un = 1'b1;
            w_flush  = 1'b1;
          end else if (w_head_st != vga_sof) begin
            w_set_mis = 1'b1;
            w_flush   = 1'b1;
          end else begin
            w_pop = 1'b1;
          end
        end
        default: w_pop = 1'b0;
      endcase
    end
  end

  // Sync state machine, pixel register and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= WAIT_START;
      pixel_rgb <= '0;
      underrun  <= 1'b0;
      overflow  <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      if (pixel_req)
        pixel_rgb <= w_pop ? w_head_rgb : '0;
      underrun <= w_set_un  | (underrun & ~clr_status);
      overflow <= w_set_ov  | (overflow & ~clr_status);
      misalign <= w_set_mis | (misalign & ~clr_status);
      if (w_flush) begin
        r_state <= WAIT_START;
      end else begin
        unique case (r_state)
          WAIT_START: if (w_push) r_state <= WAIT_ALIGN;
          WAIT_ALIGN: if (w_pop)  r_state <= RUN;
          default:    r_state <= r_state;
        endcase
      end
    end
  end

  vga_fifo_sync #(
    .AW (FIFO_AW),
    .DW (DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (w_din),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

endmodule

// File: tb/tb_video_frame_fifo.sv
// Bench for video_frame_fifo: directed scenarios plus
// random traffic against a queue-based frame model.
module tb_video_frame_fifo;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        source_vld = 1'b0;
  vga_frame_t  source_frame = '0;
  logic        stall;
  logic        pixel_req = 1'b0;
  logic        vga_sof = 1'b0;
  logic [11:0] pixel_rgb;
  logic        clr_status = 1'b0;
  logic        underrun;
  logic        overflow;
  logic        misalign;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit          st;
    logic [11:0] rgb;
  } ent_t;
  typedef enum {M_WS, M_WA, M_RUN} mode_t;

  ent_t        q[$];
  mode_t       mode;
  logic [11:0] m_rgb;
  bit          m_un, m_ov, m_mis;

  video_frame_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .source_vld   (source_vld),
    .source_frame (source_frame),
    .stall        (stall),
    .pixel_req    (pixel_req),
    .vga_sof      (vga_sof),
    .pixel_rgb    (pixel_rgb),
    .clr_status   (clr_status),
    .underrun     (underrun),
    .overflow     (overflow),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    mode  = M_WS;
    m_rgb = '0;
    m_un  = 0;
    m_ov  = 0;
    m_mis = 0;
  endfunction

  function automatic void model_step();
    bit   full  = (q.size() == 16);
    bit   empty = (q.size() == 0);
    bit   pop = 0, flush = 0, un = 0, mis = 0, acc;
    ent_t e;
    if (pixel_req) begin
      m_rgb = '0;
      if (mode == M_WA && vga_sof) pop = 1;
      else if (mode == M_RUN) begin
        if (empty) begin
          un = 1; flush = 1;
        end else if (q[0].st != vga_sof) begin
          mis = 1; flush = 1;
        end else pop = 1;
      end
      if (pop) m_rgb = q[0].rgb;
    end
    acc = source_vld && !full && !flush &&
          (mode != M_WS || source_frame.start);
    m_un  = un  || (m_un  && !clr_status);
    m_mis = mis || (m_mis && !clr_status);
    m_ov  = (source_vld && full) ||
            (m_ov && !clr_status);
    if (flush) begin
      q.delete();
      mode = M_WS;
    end else begin
      if (pop) begin
        q.delete(0);
        if (mode == M_WA) mode = M_RUN;
      end
      if (acc) begin
        e.st  = source_frame.start;
        e.rgb = {source_frame.r, source_frame.g,
                 source_frame.b};
        q.push_back(e);
        if (mode == M_WS) mode = M_WA;
      end
    end
  endfunction

  task automatic cyc(bit vld, bit st, logic [11:0] rgb,
                     bit req, bit sof, bit clr);
    source_vld         = vld;
    source_frame.start = st;
    source_frame.hc    = 10'($urandom);
    source_frame.vc    = 10'($urandom);
    source_frame.r     = rgb[11:8];
    source_frame.g     = rgb[7:4];
    source_frame.b     = rgb[3:0];
    pixel_req          = req;
    vga_sof            = sof;
    clr_status         = clr;
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    chk("rgb", pixel_rgb, m_rgb);
    chk("stall", stall, q.size() >= 12);
    chk("underrun", underrun, m_un);
    chk("overflow", overflow, m_ov);
    chk("misalign", misalign, m_mis);
    chk("count", dut.w_count, q.size());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_rgb", pixel_rgb, 0);
    chk("rst_stall", stall, 0);
    chk("rst_flags", {underrun, overflow, misalign}, 0);

    // normal fill, reads overlapped so stall stays low
    cyc(1, 1, 12'h001, 0, 0, 0);
    for (int i = 2; i <= 12; i++) begin
      cyc(1, 0, 12'(i), 1, i == 2, 0);
      chk("nf_px", pixel_rgb, i - 1);
      chk("nf_stall", stall, 0);
    end
    cyc(0, 0, 0, 1, 0, 0);
    chk("nf_px", pixel_rgb, 12);

    // stall threshold and overflow
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      cyc(1, i == 1, 12'(i), 0, 0, 0);
      if (i == 11) chk("th_stall_lo", stall, 0);
    end
    chk("th_stall_hi", stall, 1);
    for (int i = 13; i <= 16; i++) begin
      cyc(1, 0, 12'(i), 0, 0, 0);
      chk("th_no_ovf", overflow, 0);
    end
    chk("th_cnt16", dut.w_count, 16);
    cyc(1, 0, 12'h011, 0, 0, 0);
    chk("th_ovf", overflow, 1);
    chk("th_cnt16b", dut.w_count, 16);

    // sync discard
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 12'(i), 0, 0, 0);
    chk("sd_cnt0", dut.w_count, 0);
    cyc(1, 1, 12'hABC, 0, 0, 0);
    chk("sd_cnt1", dut.w_count, 1);
    cyc(0, 0, 0, 1, 1, 0);
    chk("sd_px", pixel_rgb, 12'hABC);

    // underrun
    cyc(1, 0, 12'h123, 0, 0, 0);
    chk("ur_cnt1", dut.w_count, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("ur_px", pixel_rgb, 12'h123);
    cyc(0, 0, 0, 1, 0, 0);
    chk("ur_px0", pixel_rgb, 0);
    chk("ur_flag", underrun, 1);
    chk("ur_cnt0", dut.w_count, 0);
    cyc(1, 0, 12'h055, 0, 0, 0);
    chk("ur_ws_discard", dut.w_count, 0);

    // misalignment with a push in the flush cycle
    do_reset();
    cyc(1, 1, 12'h111, 0, 0, 0);
    cyc(1, 0, 12'h222, 0, 0, 0);
    cyc(1, 1, 12'h333, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("ma_px1", pixel_rgb, 12'h111);
    cyc(0, 0, 0, 1, 0, 0);
    chk("ma_px2", pixel_rgb, 12'h222);
    cyc(1, 1, 12'h444, 1, 0, 0);
    chk("ma_px0", pixel_rgb, 0);
    chk("ma_flag", misalign, 1);
    chk("ma_cnt0", dut.w_count, 0);

    // reset mid-stream, then set-beats-clear
    for (int i = 0; i < 9; i++)
      cyc(1, i == 0, 12'(i + 'h50), 0, 0, 0);
    chk("rm_cnt9", dut.w_count, 9);
    chk("rm_mis", misalign, 1);
    do_reset();
    chk("rm_rgb", pixel_rgb, 0);
    chk("rm_flags", {underrun, overflow, misalign}, 0);
    chk("rm_cnt0", dut.w_count, 0);
    cyc(1, 1, 12'h777, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("sc_px", pixel_rgb, 12'h777);
    cyc(0, 0, 0, 1, 0, 1);
    chk("sc_setwins", underrun, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("sc_clr", underrun, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      cyc($urandom_range(0, 99) < 60,
          $urandom_range(0, 9) == 0,
          12'($urandom),
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 19) == 0);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
